// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM states, default width, two's-complement helper.
package alu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } div_state_t;

   localparam int DIV_W_DEFAULT = 32;
   localparam int NEG_W         = 64;

   // Callers zero-extend into NEG_W and truncate the result back; the low bits are exact mod 2^N.
   function automatic logic [NEG_W-1:0] neg2c(input logic [NEG_W-1:0] x);
      return ~x + NEG_W'(1);
   endfunction

endpackage

// File: rtl/nadder.sv
// Ripple-carry adder reused as the divider's trial subtractor.
module nadder #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   logic [W:0] c;

   always_comb begin
      c    = '0;
      sum  = '0;
      c[0] = cin;
      for (int unsigned i = 0; i < W; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      cout = c[W];
   end

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU; one quotient bit per clock.
module seq_divider
   import alu_pkg::*;
#(
   parameter int N = DIV_W_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         is_signed,
   input  logic         abort,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero
);

   localparam int CNT_W = $clog2(N);

   div_state_t   state_q;
   logic         sign_quo_q, sign_rem_q, dbz_pend_q;
   logic [N-1:0] a_orig_q, dvd_q, dvs_q;
   logic [N:0]   prem_q;
   logic [CNT_W-1:0] cnt_q;
   logic         busy_q, done_q, dbz_q;
   logic [N-1:0] quo_q, rem_q;

   logic [N-1:0] mag_a, mag_b, quo_fix, rem_fix;
   logic [N:0]   shifted, diff, prem_d;
   logic [N-1:0] dvd_d;
   logic         no_borrow;

   always_comb begin
      mag_a = (is_signed && a[N-1]) ? N'(neg2c(NEG_W'(a))) : a;
      mag_b = (is_signed && b[N-1]) ? N'(neg2c(NEG_W'(b))) : b;
   end

   assign shifted = (prem_q << 1) | (N+1)'(dvd_q[N-1]);

   nadder #(
      .W(N + 1)
   ) u_sub (
      .a    (shifted),
      .b    (~{1'b0, dvs_q}),
      .cin  (1'b1),
      .sum  (diff),
      .cout (no_borrow)
   );

   always_comb begin
      prem_d = no_borrow ? diff : shifted;
      dvd_d  = {dvd_q[N-2:0], no_borrow};
   end

   // A zero divisor makes every trial succeed; the fixed results are substituted instead of sign fix-up.
   always_comb begin
      quo_fix = sign_quo_q ? N'(neg2c(NEG_W'(dvd_q))) : dvd_q;
      rem_fix = sign_rem_q ? N'(neg2c(NEG_W'(prem_q[N-1:0]))) : prem_q[N-1:0];
      if (dbz_pend_q) begin
         quo_fix = '1;
         rem_fix = a_orig_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         sign_quo_q <= 1'b0;
         sign_rem_q <= 1'b0;
         dbz_pend_q <= 1'b0;
         a_orig_q   <= '0;
         dvd_q      <= '0;
         dvs_q      <= '0;
         prem_q     <= '0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         dbz_q      <= 1'b0;
         quo_q      <= '0;
         rem_q      <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (start && !abort) begin
                  sign_quo_q <= is_signed & (a[N-1] ^ b[N-1]);
                  sign_rem_q <= is_signed & a[N-1];
                  dbz_pend_q <= (b == '0);
                  a_orig_q   <= a;
                  dvd_q      <= mag_a;
                  dvs_q      <= mag_b;
                  prem_q     <= '0;
                  cnt_q      <= '0;
                  busy_q     <= 1'b1;
                  state_q    <= CALC;
               end else begin
                  state_q <= IDLE;
               end
            end
            CALC: begin
               if (abort) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  prem_q <= prem_d;
                  dvd_q  <= dvd_d;
                  cnt_q  <= cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(N - 1)) begin
                     state_q <= FIX;
                  end
               end
            end
            FIX: begin
               busy_q <= 1'b0;
               if (abort) begin
                  state_q <= IDLE;
               end else begin
                  quo_q   <= quo_fix;
                  rem_q   <= rem_fix;
                  dbz_q   <= dbz_pend_q;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider at the default 32-bit width.
module tb_seq_divider;

   logic        clk = 1'b0;
   logic        rst_n, start, is_signed, abort;
   logic [31:0] a, b;
   logic        busy, done, div_by_zero;
   logic [31:0] quotient, remainder;

   int checks = 0;
   int errors = 0;
   int edges, bcnt, nd;

   always #5 clk = ~clk;

   seq_divider #(
      .N(32)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .is_signed   (is_signed),
      .abort       (abort),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic sg, input logic [31:0] av, input logic [31:0] bv);
      start     = 1'b1;
      is_signed = sg;
      a         = av;
      b         = bv;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int e, output int bc);
      e  = 0;
      bc = busy ? 1 : 0;
      while (e < 100) begin
         @(posedge clk);
         #1;
         e++;
         if (done) break;
         if (busy) bc++;
      end
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic count_dones(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (done) cnt++;
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; abort = 1'b0; a = '0; b = '0;
      #23;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_quo", quotient, 0);
      check("rst_rem", remainder, 0);
      check("rst_dbz", div_by_zero, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle_cycle();

      // 1: DIVU 100/7, latency and busy width
      issue(1'b0, 32'd100, 32'd7);
      wait_done(edges, bcnt);
      check("t1_done", done, 1);
      check("t1_latency", edges, 33);
      check("t1_busy_cycles", bcnt, 33);
      check("t1_quo", quotient, 14);
      check("t1_rem", remainder, 2);
      check("t1_dbz", div_by_zero, 0);
      idle_cycle();
      check("t1_done_pulse", done, 0);
      check("t1_quo_hold", quotient, 14);

      // 2: signed cases
      issue(1'b1, 32'hFFFF_FFF9, 32'd2);
      wait_done(edges, bcnt);
      check("t2a_quo", quotient, 32'hFFFF_FFFD);
      check("t2a_rem", remainder, 32'hFFFF_FFFF);
      idle_cycle();
      issue(1'b1, 32'd7, 32'hFFFF_FFFE);
      wait_done(edges, bcnt);
      check("t2b_quo", quotient, 32'hFFFF_FFFD);
      check("t2b_rem", remainder, 1);
      idle_cycle();

      // 3: overflow and unsigned max
      issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(edges, bcnt);
      check("t3a_quo", quotient, 32'h8000_0000);
      check("t3a_rem", remainder, 0);
      check("t3a_dbz", div_by_zero, 0);
      idle_cycle();
      issue(1'b0, 32'hFFFF_FFFF, 32'd1);
      wait_done(edges, bcnt);
      check("t3b_quo", quotient, 32'hFFFF_FFFF);
      check("t3b_rem", remainder, 0);
      idle_cycle();

      // 4: divide by zero, both signedness
      issue(1'b0, 32'h1234_5678, 32'd0);
      wait_done(edges, bcnt);
      check("t4a_latency", edges, 33);
      check("t4a_quo", quotient, 32'hFFFF_FFFF);
      check("t4a_rem", remainder, 32'h1234_5678);
      check("t4a_dbz", div_by_zero, 1);
      idle_cycle();
      issue(1'b1, 32'h1234_5678, 32'd0);
      wait_done(edges, bcnt);
      check("t4b_quo", quotient, 32'hFFFF_FFFF);
      check("t4b_rem", remainder, 32'h1234_5678);
      check("t4b_dbz", div_by_zero, 1);
      idle_cycle();
      issue(1'b0, 32'd9, 32'd3);
      wait_done(edges, bcnt);
      check("t4c_dbz", div_by_zero, 0);
      check("t4c_quo", quotient, 3);
      check("t4c_rem", remainder, 0);
      idle_cycle();

      // 5: start while busy ignored
      issue(1'b0, 32'd100, 32'd7);
      for (int i = 0; i < 4; i++) idle_cycle();
      issue(1'b0, 32'd50, 32'd5);
      wait_done(edges, bcnt);
      check("t5a_done", done, 1);
      check("t5a_quo", quotient, 14);
      check("t5a_rem", remainder, 2);
      idle_cycle();

      // 5: abort mid-calculation
      issue(1'b0, 32'd50, 32'd5);
      for (int i = 0; i < 9; i++) idle_cycle();
      abort = 1'b1;
      idle_cycle();
      abort = 1'b0;
      check("t5b_busy", busy, 0);
      check("t5b_done", done, 0);
      count_dones(40, nd);
      check("t5b_no_done", nd, 0);
      check("t5b_quo", quotient, 14);
      check("t5b_rem", remainder, 2);

      // abort suppresses a same-cycle start in IDLE
      abort = 1'b1;
      issue(1'b0, 32'd9, 32'd3);
      abort = 1'b0;
      check("t5c_busy", busy, 0);
      idle_cycle();

      // 5: reset mid-operation
      issue(1'b1, 32'd81, 32'd9);
      for (int i = 0; i < 19; i++) idle_cycle();
      rst_n = 1'b0;
      #1;
      check("t5d_busy", busy, 0);
      check("t5d_done", done, 0);
      check("t5d_quo", quotient, 0);
      check("t5d_rem", remainder, 0);
      check("t5d_dbz", div_by_zero, 0);
      idle_cycle();
      rst_n = 1'b1;
      count_dones(40, nd);
      check("t5d_no_done", nd, 0);

      // 6: back-to-back start in the DONE cycle
      issue(1'b0, 32'd100, 32'd7);
      wait_done(edges, bcnt);
      check("t6a_done", done, 1);
      check("t6a_quo", quotient, 14);
      issue(1'b0, 32'd81, 32'd9);
      check("t6_no_consec_done", done, 0);
      check("t6_busy", busy, 1);
      check("t6_quo_hold", quotient, 14);
      wait_done(edges, bcnt);
      check("t6b_latency", edges, 33);
      check("t6b_quo", quotient, 9);
      check("t6b_rem", remainder, 0);
      idle_cycle();
      check("t6b_done_pulse", done, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
